// File: rtl/dsr_share_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : dsr_share_arb_if
//  Purpose  : Handshake bundle for the shared right-shifter arbiter. Carries
//             two requester channels and one result channel.
//             res_sticky exists only when DSR_SHARE_ARB_STICKY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface dsr_share_arb_if #(
  parameter int N = 16,
  parameter int S = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_data;
  logic [S-1:0] req0_shamt;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_data;
  logic [S-1:0] req1_shamt;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_id;
`ifdef DSR_SHARE_ARB_STICKY_EN
  logic         res_sticky;
`endif

  // Requesters and result consumer side
  modport master (
    output req0_valid, req0_data, req0_shamt,
    output req1_valid, req1_data, req1_shamt,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id
`ifdef DSR_SHARE_ARB_STICKY_EN
    , input res_sticky
`endif
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_data, req0_shamt,
    input  req1_valid, req1_data, req1_shamt,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id
`ifdef DSR_SHARE_ARB_STICKY_EN
    , output res_sticky
`endif
  );
endinterface
`default_nettype wire

// File: rtl/dsr_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : dsr_share_arb
//  Purpose  : Two requesters share one staged logical right shifter through a
//             round-robin arbiter; the result sits in a single output register
//             that can reload on the same edge it is drained.
//             Optional sticky output enabled by macro DSR_SHARE_ARB_STICKY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module dsr_share_arb #(
  parameter int N = 16,
  parameter int S = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  dsr_share_arb_if.slave   bus
);

  localparam logic [0:0] c_EMPTY = 1'b0;
  localparam logic [0:0] c_FULL  = 1'b1;

  logic [0:0]   r_state;
  logic [0:0]   w_next_state;
  logic         r_rr_ptr;      // 1: requester 1 wins the next tie
  logic         w_accept;
  logic         w_gnt0;
  logic         w_gnt1;
  logic         w_load;
  logic [N-1:0] w_sel_data;
  logic [S-1:0] w_sel_shamt;
  logic [N-1:0] w_stage [0:S];
  logic [N-1:0] r_data;
  logic         r_id;

  assign w_load      = w_gnt0 | w_gnt1;
  assign w_sel_data  = w_gnt1 ? bus.req1_data  : bus.req0_data;
  assign w_sel_shamt = w_gnt1 ? bus.req1_shamt : bus.req0_shamt;
  assign w_stage[0]  = w_sel_data;

  // Shifter: stage k conditionally shifts by 2^k, zero filling from the top
  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int c_AMT = 1 << k;
    assign w_stage[k+1] = w_sel_shamt[k] ? (w_stage[k] >> c_AMT) : w_stage[k];
  end

`ifdef DSR_SHARE_ARB_STICKY_EN
  logic [S:0] w_stk;
  logic       r_sticky;
  assign w_stk[0] = 1'b0;

  // Sticky: accumulate the bits each active stage pushes off the bottom
  for (genvar k = 0; k < S; k++) begin : g_sticky
    localparam int           c_LOST = ((1 << k) > N) ? N : (1 << k);
    localparam logic [N-1:0] c_MASK = {N{1'b1}} >> (N - c_LOST);
    assign w_stk[k+1] = w_stk[k] | (w_sel_shamt[k] & (|(w_stage[k] & c_MASK)));
  end
`endif

  // State register: EMPTY/FULL of the result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_EMPTY;
    else     r_state <= w_next_state;
  end

  // Next state: load fills, drain without reload empties
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_EMPTY: if (w_load) w_next_state = c_FULL;
      c_FULL:  if (bus.res_ready && !w_load) w_next_state = c_EMPTY;
      default: w_next_state = c_EMPTY;
    endcase
  end

  // Outputs: grant decision, readies and result valid; nothing granted in reset
  always_comb begin
    w_accept = (r_state == c_EMPTY) || bus.res_ready;
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    if (!rst && w_accept) begin
      if (bus.req0_valid && (!bus.req1_valid || !r_rr_ptr)) w_gnt0 = 1'b1;
      else if (bus.req1_valid)                              w_gnt1 = 1'b1;
    end
    bus.req0_ready = w_gnt0;
    bus.req1_ready = w_gnt1;
    bus.res_valid  = (r_state == c_FULL);
  end

  // Round-robin pointer moves only on a real grant, toward the other requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_rr_ptr <= 1'b0;
    else if (w_load) r_rr_ptr <= w_gnt0;
  end

  // Result register: captures the shifted operand and owner on a grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_id   <= 1'b0;
    end else if (w_load) begin
      r_data <= w_stage[S];
      r_id   <= w_gnt1;
    end
  end

  assign bus.res_data = r_data;
  assign bus.res_id   = r_id;

`ifdef DSR_SHARE_ARB_STICKY_EN
  // Sticky register travels with the result data
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_sticky <= 1'b0;
    else if (w_load) r_sticky <= w_stk[S];
  end
  assign bus.res_sticky = r_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dsr_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsr_share_arb
//  Purpose  : Scoreboard bench for dsr_share_arb: directed cases followed by
//             random traffic compared against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dsr_share_arb;
  localparam int N = 16;
  localparam int S = 4;

  typedef struct {
    logic [N-1:0] data;
    logic         id;
    logic         sticky;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  res_t q[$];
  res_t pend;
  bit   have_pend = 0;
  int   last_gnt  = 1;   // requester granted most recently; 1 -> 0 wins first tie
  bit   exp_rdy0  = 0;
  bit   exp_rdy1  = 0;

  dsr_share_arb_if #(.N(N), .S(S)) bus ();

  dsr_share_arb #(.N(N), .S(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_sticky();
`ifdef DSR_SHARE_ARB_STICKY_EN
    return bus.res_sticky;
`else
    return 1'b0;
`endif
  endfunction

  // One bus cycle: drive inputs after the edge and predict the arbiter's choice
  task automatic cycle(input bit v0, input logic [N-1:0] d0, input logic [S-1:0] s0,
                       input bit v1, input logic [N-1:0] d1, input logic [S-1:0] s1,
                       input bit rr);
    bit full, accept;
    int g;
    logic [N-1:0] d;
    int sh;
    @(posedge clk); #1;
    if (have_pend) begin
      q.push_back(pend);
      have_pend = 0;
    end
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_shamt = s0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_shamt = s1;
    bus.res_ready  = rr;
    full   = (q.size() != 0);
    accept = !full || rr;
    g = -1;
    if (accept) begin
      if (v0 && v1)  g = 1 - last_gnt;
      else if (v0)   g = 0;
      else if (v1)   g = 1;
    end
    exp_rdy0 = (g == 0);
    exp_rdy1 = (g == 1);
    if (g >= 0) begin
      d  = (g == 1) ? d1 : d0;
      sh = (g == 1) ? int'(s1) : int'(s0);
      pend.data = d / (N'(1) << sh);       // logical right shift as division
      pend.id   = (g == 1);
`ifdef DSR_SHARE_ARB_STICKY_EN
      pend.sticky = (d % (N'(1) << sh)) != 0;
`else
      pend.sticky = 1'b0;
`endif
      have_pend = 1;
      last_gnt  = g;
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_data = '0; bus.req0_shamt = '0;
    bus.req1_valid = 0; bus.req1_data = '0; bus.req1_shamt = '0;
    bus.res_ready  = 1;
    exp_rdy0 = 0;
    exp_rdy1 = 0;
  endtask

  // Asynchronous reset in mid-cycle with requests still pending
  task automatic async_reset();
    #2 rst = 1;
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_data",  32'(bus.res_data),  0);
    chk("rst_res_id",    32'(bus.res_id),    0);
    chk("rst_res_sticky",32'(get_sticky()),  0);
    chk("rst_ready0",    32'(bus.req0_ready), 0);
    chk("rst_ready1",    32'(bus.req1_ready), 0);
    q.delete();
    have_pend = 0;
    last_gnt  = 1;
    @(posedge clk); #1;
    chk("rst_ready_held", 32'({bus.req0_ready, bus.req1_ready}), 0);
    idle_inputs();
    rst = 0;
  endtask

  // Monitor: compare the held result and readies against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      chk("res_valid", 32'(bus.res_valid), 32'(q.size() != 0));
      chk("ready0", 32'(bus.req0_ready), 32'(exp_rdy0));
      chk("ready1", 32'(bus.req1_ready), 32'(exp_rdy1));
      if (q.size() != 0) begin
        chk("res_data",   32'(bus.res_data), 32'(q[0].data));
        chk("res_id",     32'(bus.res_id),   32'(q[0].id));
        chk("res_sticky", 32'(get_sticky()), 32'(q[0].sticky));
        if (bus.res_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.res_valid), 0);
    chk("reset_data",  32'(bus.res_data),  0);
    chk("reset_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
    rst = 0;

    // Single requester 0: F0F0 >> 4
    cycle(1, 16'hF0F0, 4'd4, 0, '0, '0, 1);
    cycle(0, '0, '0, 0, '0, '0, 1);

    // Contention with consumer always ready: alternating grants
    for (int i = 0; i < 6; i++)
      cycle(1, 16'(16'h1000 + i), 4'(i), 1, 16'(16'hA000 + i), 4'(i + 1), 1);

    // Stall with both valid for 3 cycles, then release
    for (int i = 0; i < 3; i++)
      cycle(1, 16'h1234, 4'd1, 1, 16'h5678, 4'd2, 0);
    cycle(1, 16'h1234, 4'd1, 1, 16'h5678, 4'd2, 1);
    cycle(0, '0, '0, 0, '0, '0, 1);
    cycle(0, '0, '0, 0, '0, '0, 1);

    // Shift boundaries on requester 1
    cycle(0, '0, '0, 1, 16'h8001, 4'd15, 1);
    cycle(0, '0, '0, 1, 16'h8001, 4'd0, 1);
    cycle(0, '0, '0, 0, '0, '0, 1);

    // Reset while FULL, then first tie must go to requester 0
    cycle(1, 16'hBEEF, 4'd3, 1, 16'hCAFE, 4'd5, 0);
    cycle(1, 16'hBEEF, 4'd3, 1, 16'hCAFE, 4'd5, 0);
    async_reset();
    cycle(1, 16'h4444, 4'd2, 1, 16'h8888, 4'd3, 1);
    cycle(0, '0, '0, 0, '0, '0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom),
            1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom),
            ($urandom_range(0, 9) < 7));

    // Drain
    for (int i = 0; i < 4; i++)
      cycle(0, '0, '0, 0, '0, '0, 1);
    @(posedge clk); #1;
    chk("drained", 32'(q.size() + int'(have_pend)), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
